// File: rtl/frame_buffer_ctrl_if.sv
// Bus bundle between the frame buffer controller and its writer/reader-side logic.
// master drives the frame events and enable; slave (the controller) drives buffer ownership.
interface frame_buffer_ctrl_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32
);
  logic                      enable;
  logic                      wr_frame_done;
  logic                      rd_vsync;
  logic [AXI_ADDR_WIDTH-1:0] wr_base_addr;
  logic [AXI_ADDR_WIDTH-1:0] rd_base_addr;
  logic [1:0]                wr_buf_idx;
  logic [1:0]                rd_buf_idx;
  logic                      new_frame_avail;
  logic [15:0]               frames_written;
  logic [15:0]               frames_dropped;
  logic [15:0]               frames_repeated;
  logic [1:0]                state;

  modport master (
    output enable, wr_frame_done, rd_vsync,
    input  wr_base_addr, rd_base_addr, wr_buf_idx, rd_buf_idx, new_frame_avail,
           frames_written, frames_dropped, frames_repeated, state
  );

  modport slave (
    input  enable, wr_frame_done, rd_vsync,
    output wr_base_addr, rd_base_addr, wr_buf_idx, rd_buf_idx, new_frame_avail,
           frames_written, frames_dropped, frames_repeated, state
  );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// Triple-buffer rotation between a frame writer and an HDMI reader.
// Tracks writer/pending/reader buffer ownership and frame statistics.
module frame_buffer_ctrl #(
  parameter int unsigned                AXI_ADDR_WIDTH  = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0]  FRAME_BASE_ADDR = AXI_ADDR_WIDTH'(32'h0100_0000),
  parameter logic [AXI_ADDR_WIDTH-1:0]  FRAME_STRIDE    = AXI_ADDR_WIDTH'(32'h0004_0000)
) (
  input logic               clk_100Mhz,
  input logic               rst,
  frame_buffer_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_RUN        = 2'd2
  } state_t;

  state_t                    r_state, w_nxt_state;
  logic [1:0]                r_wr_idx, r_pend_idx, r_rd_idx;
  logic [1:0]                w_nxt_wr_idx, w_nxt_pend_idx, w_nxt_rd_idx;
  logic                      r_pend_valid, w_nxt_pend_valid;
  logic [CNT_W-1:0]          r_written, r_dropped, r_repeated;
  logic [CNT_W-1:0]          w_nxt_written, w_nxt_dropped, w_nxt_repeated;
  logic                      r_wr_done_d1, r_rd_vsync_d1;
  logic [AXI_ADDR_WIDTH-1:0] r_wr_base, r_rd_base;
  logic                      w_wr_edge, w_rd_edge;

  function automatic logic [AXI_ADDR_WIDTH-1:0] base_of(input logic [1:0] idx);
    return FRAME_BASE_ADDR + AXI_ADDR_WIDTH'(idx) * FRAME_STRIDE;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign w_wr_edge = bus.wr_frame_done & ~r_wr_done_d1;
  assign w_rd_edge = bus.rd_vsync & ~r_rd_vsync_d1;

  always_ff @(posedge clk_100Mhz) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt_state;
  end

  // Buffer rotation and statistics; a simultaneous edge hands the writer's frame straight to the reader.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_wr_idx     = r_wr_idx;
    w_nxt_pend_idx   = r_pend_idx;
    w_nxt_rd_idx     = r_rd_idx;
    w_nxt_pend_valid = r_pend_valid;
    w_nxt_written    = r_written;
    w_nxt_dropped    = r_dropped;
    w_nxt_repeated   = r_repeated;
    case (r_state)
      ST_IDLE: begin
        if (bus.enable) w_nxt_state = ST_WAIT_FIRST;
      end
      ST_WAIT_FIRST, ST_RUN: begin
        if (!bus.enable) begin
          w_nxt_state = ST_IDLE;
        end else if (w_wr_edge && w_rd_edge) begin
          w_nxt_rd_idx     = r_wr_idx;
          w_nxt_wr_idx     = r_rd_idx;
          w_nxt_pend_valid = 1'b0;
          w_nxt_written    = sat_inc(r_written);
          if (r_pend_valid) w_nxt_dropped = sat_inc(r_dropped);
          w_nxt_state      = ST_RUN;
        end else if (w_wr_edge) begin
          w_nxt_wr_idx     = r_pend_idx;
          w_nxt_pend_idx   = r_wr_idx;
          w_nxt_pend_valid = 1'b1;
          w_nxt_written    = sat_inc(r_written);
          if (r_state == ST_RUN && r_pend_valid) w_nxt_dropped = sat_inc(r_dropped);
        end else if (w_rd_edge) begin
          if (r_pend_valid) begin
            w_nxt_rd_idx     = r_pend_idx;
            w_nxt_pend_idx   = r_rd_idx;
            w_nxt_pend_valid = 1'b0;
            w_nxt_state      = ST_RUN;
          end else if (r_state == ST_RUN) begin
            w_nxt_repeated = sat_inc(r_repeated);
          end
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      r_wr_idx      <= 2'd0;
      r_pend_idx    <= 2'd1;
      r_rd_idx      <= 2'd2;
      r_pend_valid  <= 1'b0;
      r_written     <= '0;
      r_dropped     <= '0;
      r_repeated    <= '0;
      r_wr_done_d1  <= 1'b0;
      r_rd_vsync_d1 <= 1'b0;
      r_wr_base     <= base_of(2'd0);
      r_rd_base     <= base_of(2'd2);
    end else begin
      r_wr_idx      <= w_nxt_wr_idx;
      r_pend_idx    <= w_nxt_pend_idx;
      r_rd_idx      <= w_nxt_rd_idx;
      r_pend_valid  <= w_nxt_pend_valid;
      r_written     <= w_nxt_written;
      r_dropped     <= w_nxt_dropped;
      r_repeated    <= w_nxt_repeated;
      r_wr_done_d1  <= bus.wr_frame_done;
      r_rd_vsync_d1 <= bus.rd_vsync;
      r_wr_base     <= base_of(w_nxt_wr_idx);
      r_rd_base     <= base_of(w_nxt_rd_idx);
    end
  end

  assign bus.wr_base_addr    = r_wr_base;
  assign bus.rd_base_addr    = r_rd_base;
  assign bus.wr_buf_idx      = r_wr_idx;
  assign bus.rd_buf_idx      = r_rd_idx;
  assign bus.new_frame_avail = r_pend_valid;
  assign bus.frames_written  = r_written;
  assign bus.frames_dropped  = r_dropped;
  assign bus.frames_repeated = r_repeated;
  assign bus.state           = r_state;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed plus random stimulus for frame_buffer_ctrl, checked against a reference model via an expected-value queue.
module tb_frame_buffer_ctrl;

  logic clk_100Mhz = 1'b0;
  logic rst        = 1'b1;
  always #5 clk_100Mhz = ~clk_100Mhz;

  frame_buffer_ctrl_if #(.AXI_ADDR_WIDTH(32)) bus ();

  frame_buffer_ctrl #(
    .AXI_ADDR_WIDTH (32),
    .FRAME_BASE_ADDR(32'h0100_0000),
    .FRAME_STRIDE   (32'h0004_0000)
  ) dut (
    .clk_100Mhz(clk_100Mhz),
    .rst       (rst),
    .bus       (bus)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic [1:0]  wi;
    logic [1:0]  ri;
    logic        nfa;
    logic [15:0] fw;
    logic [15:0] fd;
    logic [15:0] fr;
    logic [31:0] wa;
    logic [31:0] ra;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state
  int m_st, m_w, m_p, m_r, m_fw, m_fd, m_fr;
  bit m_pv, m_dw, m_dv;

  function automatic logic [31:0] addr_of(input int i);
    return 32'h0100_0000 + 32'(i) * 32'h0004_0000;
  endfunction

  function automatic int inc16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic model_step(input bit r, input bit en, input bit w, input bit v);
    bit we, re;
    int t;
    if (r) begin
      m_st = 0; m_w = 0; m_p = 1; m_r = 2; m_pv = 0;
      m_fw = 0; m_fd = 0; m_fr = 0; m_dw = 0; m_dv = 0;
    end else begin
      we = w && !m_dw;
      re = v && !m_dv;
      if (m_st == 0) begin
        if (en) m_st = 1;
      end else if (!en) begin
        m_st = 0;
      end else if (we && re) begin
        if (m_pv) m_fd = inc16(m_fd);
        m_fw = inc16(m_fw);
        t = m_w; m_w = m_r; m_r = t;
        m_pv = 0; m_st = 2;
      end else if (we) begin
        if (m_st == 2 && m_pv) m_fd = inc16(m_fd);
        m_fw = inc16(m_fw);
        t = m_w; m_w = m_p; m_p = t;
        m_pv = 1;
      end else if (re) begin
        if (m_pv) begin
          t = m_r; m_r = m_p; m_p = t;
          m_pv = 0; m_st = 2;
        end else if (m_st == 2) begin
          m_fr = inc16(m_fr);
        end
      end
      m_dw = w;
      m_dv = v;
    end
  endtask

  // One clock: drive inputs, queue the model's prediction, then compare after the edge.
  task automatic drive(input bit r, input bit en, input bit w, input bit v);
    exp_t e;
    rst               = r;
    bus.enable        = en;
    bus.wr_frame_done = w;
    bus.rd_vsync      = v;
    model_step(r, en, w, v);
    e.st = 2'(m_st); e.wi = 2'(m_w); e.ri = 2'(m_r); e.nfa = m_pv;
    e.fw = 16'(m_fw); e.fd = 16'(m_fd); e.fr = 16'(m_fr);
    e.wa = addr_of(m_w); e.ra = addr_of(m_r);
    q.push_back(e);
    @(posedge clk_100Mhz);
    #1;
    e = q.pop_front();
    chk("state",           32'(bus.state),           32'(e.st));
    chk("wr_buf_idx",      32'(bus.wr_buf_idx),      32'(e.wi));
    chk("rd_buf_idx",      32'(bus.rd_buf_idx),      32'(e.ri));
    chk("new_frame_avail", 32'(bus.new_frame_avail), 32'(e.nfa));
    chk("frames_written",  32'(bus.frames_written),  32'(e.fw));
    chk("frames_dropped",  32'(bus.frames_dropped),  32'(e.fd));
    chk("frames_repeated", 32'(bus.frames_repeated), 32'(e.fr));
    chk("wr_base_addr",    bus.wr_base_addr,         e.wa);
    chk("rd_base_addr",    bus.rd_base_addr,         e.ra);
  endtask

  initial begin
    bus.enable        = 1'b0;
    bus.wr_frame_done = 1'b0;
    bus.rd_vsync      = 1'b0;

    // Reset values
    drive(1, 0, 0, 0);
    chk("rst_state",   32'(bus.state), 32'd0);
    chk("rst_wr_addr", bus.wr_base_addr, 32'h0100_0000);
    chk("rst_rd_addr", bus.rd_base_addr, 32'h0108_0000);

    // First frame handoff
    drive(0, 1, 0, 0);
    chk("idle_to_wait", 32'(bus.state), 32'd1);
    drive(0, 1, 1, 0);
    chk("first_wr_idx", 32'(bus.wr_buf_idx), 32'd1);
    chk("first_pend",   32'(bus.new_frame_avail), 32'd1);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 1);
    chk("first_rd_idx",  32'(bus.rd_buf_idx), 32'd0);
    chk("first_run",     32'(bus.state), 32'd2);
    chk("first_rd_addr", bus.rd_base_addr, 32'h0100_0000);
    chk("first_written", 32'(bus.frames_written), 32'd1);
    drive(0, 1, 0, 0);

    // Writer outruns reader
    repeat (3) begin
      drive(0, 1, 1, 0);
      chk("wr_ne_rd", 32'(bus.wr_buf_idx != bus.rd_buf_idx), 32'd1);
      drive(0, 1, 0, 0);
    end
    chk("burst_written", 32'(bus.frames_written), 32'd4);
    chk("burst_dropped", 32'(bus.frames_dropped), 32'd2);
    chk("burst_pending", 32'(bus.new_frame_avail), 32'd1);

    // Consume pending, then reader repeats
    drive(0, 1, 0, 1);
    drive(0, 1, 0, 0);
    repeat (2) begin
      drive(0, 1, 0, 1);
      drive(0, 1, 0, 0);
    end
    chk("repeat_count",  32'(bus.frames_repeated), 32'd2);
    chk("repeat_rd_idx", 32'(bus.rd_buf_idx), 32'd1);

    // Simultaneous edges with a frame pending
    drive(0, 1, 1, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 1);
    chk("sim_rd_idx",  32'(bus.rd_buf_idx), 32'd0);
    chk("sim_wr_idx",  32'(bus.wr_buf_idx), 32'd1);
    chk("sim_pending", 32'(bus.new_frame_avail), 32'd0);
    chk("sim_dropped", 32'(bus.frames_dropped), 32'd3);
    drive(0, 1, 0, 0);

    // Long writer level is a single event
    repeat (100) drive(0, 1, 1, 0);
    chk("hold_written", 32'(bus.frames_written), 32'd7);
    drive(0, 1, 0, 0);

    // Disable with edges present
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 1);
    chk("dis_state",  32'(bus.state), 32'd0);
    chk("dis_wr_idx", 32'(bus.wr_buf_idx), 32'd2);
    chk("dis_rd_idx", 32'(bus.rd_buf_idx), 32'd0);
    drive(0, 0, 0, 0);

    // Reset right after a writer edge
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    drive(1, 1, 1, 0);
    chk("rst2_wr_idx",  32'(bus.wr_buf_idx), 32'd0);
    chk("rst2_rd_idx",  32'(bus.rd_buf_idx), 32'd2);
    chk("rst2_written", 32'(bus.frames_written), 32'd0);
    chk("rst2_pending", 32'(bus.new_frame_avail), 32'd0);

    // Random edges
    drive(0, 1, 0, 0);
    repeat (300) begin
      drive(0, $urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("rand_wr_ne_rd", 32'(bus.wr_buf_idx != bus.rd_buf_idx), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
